// File: rtl/stoch_decode_mat.sv
// stoch_decode_mat
// Decodes a matrix of stochastic bitstreams by counting ones over a window of
// N = 2^WINDOW_LOG2 valid samples. Each element has its own counter; no
// division or scaling is done, so the probability estimate is Y/N downstream.
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   RST      synchronous active-high reset
//   start    request a new decode window (honoured in IDLE, or in HOLD with y_ready)
//   A        one stochastic bit per element per cycle
//   a_valid  A carries a valid sample this cycle
//   Y        decoded per-element count of the last completed window
//   y_valid  Y holds a completed window result
//   y_ready  consumer accepts Y
//   busy     window accumulation in progress
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; Y keeps the last result
// ACCUM | counting ones on every a_valid cycle until N samples seen
// HOLD  | result presented on Y with y_valid until y_ready
module stoch_decode_mat #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                                             CLK,
    input  logic                                             RST,
    input  logic                                             start,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                A,
    input  logic                                             a_valid,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2:0] Y,
    output logic                                             y_valid,
    input  logic                                             y_ready,
    output logic                                             busy
);

    localparam int CW = WINDOW_LOG2 + 1;

    // The sample counter wraps naturally from N-1 back to 0, so the last
    // sample of a window is simply the all-ones value.
    localparam logic [WINDOW_LOG2-1:0] SCNT_LAST = '1;
    localparam logic [WINDOW_LOG2-1:0] SCNT_ONE  = WINDOW_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                                        state;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]     cnt;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]     cnt_inc;
    logic [WINDOW_LOG2-1:0]                        scnt;

    // Per-element counts including the current sample. Used both to advance
    // the counters and to load Y on the N-th sample, so Y includes it.
    always_comb begin
        cnt_inc = cnt;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = 0; j < NUM_COLS; j++) begin
                cnt_inc[i][j] = cnt[i][j] + CW'(A[i][j]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            scnt    <= '0;
            Y       <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        scnt  <= '0;
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (a_valid) begin
                        cnt  <= cnt_inc;
                        scnt <= scnt + SCNT_ONE;
                        if (scnt == SCNT_LAST) begin
                            Y       <= cnt_inc;
                            state   <= HOLD;
                            busy    <= 1'b0;
                            y_valid <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back window: skip IDLE entirely.
                            cnt   <= '0;
                            scnt  <= '0;
                            state <= ACCUM;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stoch_decode_mat.md
STOCH_DECODE_MAT -- requirements
Module: stoch_decode_mat

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 2, matrix rows.
REQ-002 SHALL have parameter NUM_COLS, default 2, matrix columns.
REQ-003 SHALL have parameter WINDOW_LOG2, default 8; the decode window is N = 2^WINDOW_LOG2 samples; legal range 1..16.
REQ-004 SHALL have localparam CW = WINDOW_LOG2+1, the per-element count width.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 CLK  input  1  clock; all state changes on rising edge.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 start  input  1  request a new decode window.
REQ-009 A  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  stochastic bitstream matrix, one bit per element per cycle.
REQ-010 a_valid  input  1  A carries a valid sample this cycle.
REQ-011 Y  output  [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]  decoded count per element.
REQ-012 y_valid  output  1  Y holds a completed window result.
REQ-013 y_ready  input  1  consumer accepts Y.
REQ-014 busy  output  1  window accumulation in progress.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, HOLD; busy = (state==ACCUM); y_valid = (state==HOLD).
REQ-016 IDLE: start=1 SHALL clear all element counters and the sample counter and enter ACCUM next cycle; otherwise remain in IDLE.
REQ-017 ACCUM: each cycle with a_valid=1, every element counter SHALL increment by its A[i][j] bit and the sample counter by 1; a_valid=0 cycles SHALL change no counter.
REQ-018 ACCUM: start SHALL be ignored.
REQ-019 When the N-th valid sample is accepted, the FSM SHALL enter HOLD next cycle with Y equal to the final counts (those including the N-th sample).
REQ-020 Latency: y_valid SHALL assert exactly one cycle after the cycle carrying the N-th valid sample.
REQ-021 Counters SHALL be CW bits wide; all-ones input over N samples SHALL yield Y = N with no wrap or saturation; all-zeros SHALL yield 0.
REQ-022 Sample counter SHALL count 0..N-1 and SHALL NOT be observable on outputs.
REQ-023 HOLD: Y SHALL stay stable while y_ready=0; A and a_valid SHALL be ignored.
REQ-024 HOLD with y_ready=1 and start=0: SHALL enter IDLE next cycle; Y retains its value but y_valid deasserts.
REQ-025 HOLD with y_ready=1 and start=1: SHALL clear counters and enter ACCUM next cycle (back-to-back windows, no IDLE cycle).
REQ-026 HOLD with start=1 and y_ready=0: start SHALL be ignored.
REQ-027 Each element SHALL decode independently; no cross-element interaction.
REQ-028 Decoded probability is Y/N; the block SHALL NOT perform any division or scaling.

Reset
REQ-029 RST=1 at a rising edge SHALL force state IDLE, Y=0, all counters 0, y_valid=0, busy=0, regardless of state or other inputs.
REQ-030 RST asserted during ACCUM or HOLD SHALL discard the partial/pending result; no y_valid SHALL follow from that window.
REQ-031 RST SHALL take priority over start, a_valid and y_ready in the same cycle.

Verification (NUM_ROWS=2, NUM_COLS=2, WINDOW_LOG2=3, N=8)
REQ-032 Reset, then start pulse, then 8 consecutive a_valid cycles with A[0][0]=1 always, A[0][1]=0 always, A[1][0] alternating 1,0, A[1][1]=1 on the first 3 samples only -> y_valid one cycle after the 8th sample with Y = {8,0,4,3}; busy low in that cycle.
REQ-033 Same as REQ-032 with a_valid deasserted for 5 cycles mid-window -> identical Y; y_valid delayed by exactly 5 cycles.
REQ-034 y_ready held 0 for 10 cycles in HOLD while A toggles and start pulses -> Y, y_valid unchanged; y_ready=1 with start=0 -> IDLE next cycle, y_valid=0.
REQ-035 y_ready=1 and start=1 in the same HOLD cycle, then 8 all-zeros samples -> busy next cycle, no IDLE cycle, second result Y = {0,0,0,0}.
REQ-036 RST asserted after 4 valid samples, then start and 8 all-ones samples -> no y_valid before the new window completes; Y = {8,8,8,8}.
